// File: rtl/sub32_bla_serial_pkg.sv
// Shared constants and FSM state type for the serial borrow-lookahead subtractor.
package sub32_bla_serial_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub32_bla_serial_sub8_bla.sv
// Combinational W-bit borrow-lookahead subtract slice: diff = a - b - bin.
// Each internal borrow is formed directly from the generate/propagate terms
// of all lower bits rather than chained bit to bit.
module sub8_bla #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] diff,
  output logic         bout
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   br;

  assign g = ~a & b;
  assign p = ~(a ^ b);

  // lookahead borrows: br[i] = OR_j (g[j] & p[j+1..i-1]) | (p[0..i-1] & bin)
  always_comb begin
    logic term;
    br = '0;
    br[0] = bin;
    for (int i = 1; i <= W; i++) begin
      term = bin;
      for (int k = 0; k < i; k++) term = term & p[k];
      br[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) term = term & p[k];
        br[i] = br[i] | term;
      end
    end
  end

  assign diff = a ^ b ^ br[W-1:0];
  assign bout = br[W];

endmodule

// File: rtl/sub32_bla_serial.sv
// Serial subtractor: one SLICE_W-bit lookahead slice per cycle, LSB first,
// with the inter-slice borrow held in a register. Valid/ready on both sides.
module sub32_bla_serial
  import sub32_bla_serial_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SLICE_W = DEF_SLICE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             z,
  output logic             n,
  output logic             v
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NSLICE - 1);

  state_t             state, nxt;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               brw;
  logic [IDX_W-1:0]   idx;
  logic [SLICE_W-1:0] s_a, s_b, s_diff;
  logic               s_bout;
  logic [WIDTH-1:0]   diff_full;

  assign s_a = a_q[int'(idx)*SLICE_W +: SLICE_W];
  assign s_b = b_q[int'(idx)*SLICE_W +: SLICE_W];

  sub8_bla #(.W(SLICE_W)) u_slice (
    .a    (s_a),
    .b    (s_b),
    .bin  (brw),
    .diff (s_diff),
    .bout (s_bout)
  );

  // result with the current slice merged in; used for flags on the last slice
  always_comb begin
    diff_full = diff;
    diff_full[int'(idx)*SLICE_W +: SLICE_W] = s_diff;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (in_valid)    nxt = RUN;
      RUN:     if (idx == LAST) nxt = DONE;
      DONE:    if (out_ready)   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // operand capture, slice sequencing and result/flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      brw  <= 1'b0;
      idx  <= '0;
      diff <= '0;
      bout <= 1'b0;
      z    <= 1'b0;
      n    <= 1'b0;
      v    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q <= a;
          b_q <= b;
          brw <= bin;
          idx <= '0;
        end
        RUN: begin
          diff[int'(idx)*SLICE_W +: SLICE_W] <= s_diff;
          brw <= s_bout;
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            bout <= s_bout;
            z    <= (diff_full == '0);
            n    <= diff_full[WIDTH-1];
            v    <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ diff_full[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sub32_bla_serial.md
SUB32_BLA_SERIAL -- requirements
Module: sub32_bla_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; a multiple of SLICE_W.
REQ-002 SHALL have parameter SLICE_W, default 8, bits subtracted per cycle.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operands valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  minuend.
REQ-008 SHALL have port b  input  WIDTH  subtrahend.
REQ-009 SHALL have port bin  input  1  borrow-in.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-013 SHALL have port bout  output  1  final borrow-out; 1 iff unsigned a < b + bin.
REQ-014 SHALL have ports z, n, v  output  1 each  zero, negative (diff MSB), signed overflow.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; in_ready = 1 only in IDLE.
REQ-016 SHALL accept operands on a cycle with in_valid && in_ready: latch a, b, borrow register <= bin, slice index <= 0, go to RUN.
REQ-017 SHALL in RUN compute one SLICE_W-bit slice per cycle, LSB slice first: diff slice = a slice - b slice - borrow, borrow register <= slice borrow-out.
REQ-018 SHALL, after the last slice (WIDTH/SLICE_W = 4 cycles), enter DONE with out_valid = 1.
REQ-019 SHALL give fixed latency: accept on cycle T -> out_valid high in cycle T+5, independent of operand values.
REQ-020 SHALL hold diff, bout, z, n, v stable while out_valid && !out_ready.
REQ-021 SHALL return to IDLE on out_valid && out_ready; in_ready rises the following cycle (no same-cycle re-accept).
REQ-022 SHALL ignore in_valid, a, b, bin while not in IDLE.
REQ-023 SHALL compute z = (diff == 0), n = diff[WIDTH-1], v = (a[MSB] ^ b[MSB]) & (a[MSB] ^ diff[MSB]), all registered with diff.
REQ-024 SHALL produce correct wrap-around: 0 - 1 -> all ones with bout = 1.
REQ-025 SHALL carry the borrow between slices in the registered borrow, never combinationally across slices.

Reset
REQ-026 SHALL on rst_n low force IDLE, diff = 0, bout = z = n = v = 0, out_valid = 0, borrow register = 0, slice index = 0.
REQ-027 SHALL abort any operation in RUN or DONE on reset without emitting a result; in_ready = 1 immediately after release.

Structure
REQ-028 SHALL place the FSM state typedef and WIDTH/SLICE_W default constants in a shared package.
REQ-029 SHALL instantiate one sub-module sub8_bla: combinational SLICE_W-bit borrow-lookahead slice, borrow-generate ~a&b, borrow-propagate ~(a^b), inputs a, b, borrow-in, outputs diff, borrow-out.
REQ-030 SHALL reuse that single sub8_bla instance for every slice, selected by slice index.

Verification
REQ-031 SHALL test a=5, b=3, bin=0 -> diff=2, bout=0, z=n=v=0, out_valid exactly 5 cycles after accept.
REQ-032 SHALL test a=0, b=1, bin=0 -> diff=0xFFFFFFFF, bout=1, n=1, v=0.
REQ-033 SHALL test a=0x80000000, b=1 -> diff=0x7FFFFFFF, v=1, bout=0; and a=0x00000100, b=1 -> diff=0x000000FF (cross-slice borrow).
REQ-034 SHALL test a=0x12345678, b=0x12345677, bin=1 -> diff=0, z=1, bout=0.
REQ-035 SHALL test back-pressure: out_ready low 3 cycles in DONE -> outputs stable, in_ready=0, concurrent in_valid ignored; one cycle after out_ready=1, in_ready=1.
REQ-036 SHALL test rst_n pulsed low during RUN -> out_valid stays 0, all outputs 0, in_ready=1 after release, next operation correct.
